// File: rtl/program_run_checker_if.sv
// Checker <-> processor-under-test bus: DUT reset/done, check-table lookup and probe read-back.
`timescale 1ns/1ps
interface program_run_checker_if #(
  parameter int DW         = 8,
  parameter int AW         = 8,
  parameter int NUM_CHECKS = 4
);
  localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  logic          dut_reset;
  logic          dut_done;
  logic [IW-1:0] chk_idx;
  logic          chk_sel;
  logic [AW-1:0] chk_addr;
  logic [DW-1:0] chk_exp;
  logic          probe_sel;
  logic [AW-1:0] probe_addr;
  logic [DW-1:0] probe_data;

  modport master (
    output dut_reset, chk_idx, probe_sel, probe_addr,
    input  dut_done, chk_sel, chk_addr, chk_exp, probe_data
  );

  modport slave (
    input  dut_reset, chk_idx, probe_sel, probe_addr,
    output dut_done, chk_sel, chk_addr, chk_exp, probe_data
  );
endinterface

// File: rtl/program_run_checker.sv
// Run controller and result checker for the Top processor: reset, run with timeout, walk check table.
// Optional RUN-cycle counter output enabled by defining CYCLE_COUNT_EN.
`timescale 1ns/1ps
module program_run_checker #(
  parameter int  DW         = 8,
  parameter int  AW         = 8,
  parameter int  NUM_CHECKS = 4,
  parameter int  RST_CYCLES = 2,
  parameter int  TIMEOUT    = 1024,
  parameter int  CW         = 16,
  localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int EW = $clog2(NUM_CHECKS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  program_run_checker_if.master bus,
  output logic          busy,
  output logic          finished,
  output logic          pass,
  output logic          timed_out,
  output logic [EW-1:0] err_count,
  output logic [IW-1:0] first_err_idx
`ifdef CYCLE_COUNT_EN
  ,
  output logic [CW-1:0] run_cycles
`endif
);

  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD_RST,
    S_RUN,
    S_CHK_REQ,
    S_CHK_CMP,
    S_DONE
  } state_t;

  state_t        state, state_next;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] run_cnt;
  logic [DW-1:0] probe_val;
  logic [AW-1:0] probe_loc;
  logic          hold_last;
  logic          run_last;
  logic          chk_last;
  logic          mismatch;

  assign probe_loc      = bus.chk_addr;
  assign bus.probe_addr = probe_loc;
  assign bus.probe_sel  = bus.chk_sel;
  assign probe_val      = bus.probe_data;

  // run_cnt holds completed RUN cycles, so the current RUN cycle number is run_cnt+1
  assign hold_last = (hold_cnt == HW'(RST_CYCLES - 1));
  assign run_last  = (run_cnt == TW'(TIMEOUT - 1));
  assign chk_last  = (bus.chk_idx == IW'(NUM_CHECKS - 1));
  assign mismatch  = (probe_val != bus.chk_exp);

  assign busy     = (state == S_HOLD_RST) || (state == S_RUN) ||
                    (state == S_CHK_REQ)  || (state == S_CHK_CMP);
  assign finished = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_HOLD_RST;
      S_HOLD_RST:     if (hold_last) state_next = S_RUN;
      S_RUN: begin
        if (bus.dut_done)  state_next = S_CHK_REQ;
        else if (run_last) state_next = S_DONE;
      end
      S_CHK_REQ:      state_next = S_CHK_CMP;
      S_CHK_CMP:      state_next = chk_last ? S_DONE : S_CHK_REQ;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dut_reset <= 1'b1;
      bus.chk_idx   <= '0;
      hold_cnt      <= '0;
      run_cnt       <= '0;
      pass          <= 1'b0;
      timed_out     <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
`ifdef CYCLE_COUNT_EN
      run_cycles    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            bus.dut_reset <= 1'b1;
            bus.chk_idx   <= '0;
            hold_cnt      <= '0;
            run_cnt       <= '0;
            pass          <= 1'b0;
            timed_out     <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
`ifdef CYCLE_COUNT_EN
            run_cycles    <= '0;
`endif
          end
        end
        S_HOLD_RST: begin
          hold_cnt <= hold_cnt + HW'(1);
          if (hold_last) bus.dut_reset <= 1'b0;
        end
        S_RUN: begin
          run_cnt <= run_cnt + TW'(1);
`ifdef CYCLE_COUNT_EN
          if (run_cycles != '1) run_cycles <= run_cycles + CW'(1);
`endif
          // Done in the same cycle as the timeout still goes on to the checks
          if (!bus.dut_done && run_last) begin
            timed_out <= 1'b1;
            pass      <= 1'b0;
          end
        end
        S_CHK_CMP: begin
          if (mismatch) begin
            err_count <= err_count + EW'(1);
            if (err_count == '0) first_err_idx <= bus.chk_idx;
          end
          if (chk_last) pass <= !mismatch && (err_count == '0);
          else          bus.chk_idx <= bus.chk_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_run_checker.sv
// Scoreboard bench for program_run_checker: models the processor, its memories and the check table.
`timescale 1ns/1ps
module tb_program_run_checker;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int N   = 3;
  localparam int RST = 2;
  localparam int TO  = 16;
  localparam int CW  = 16;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int EW  = $clog2(N + 1);

  typedef struct {
    logic pass;
    logic to;
    int   err;
    int   first;
    int   idx;
    int   runlen;
    int   cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, finished, pass, timed_out;
  logic [EW-1:0] err_count;
  logic [IW-1:0] first_err_idx;
`ifdef CYCLE_COUNT_EN
  logic [CW-1:0] run_cycles;
`endif

  logic [DW-1:0] regs [0:255];
  logic [DW-1:0] mem  [0:255];
  logic          tbl_sel  [0:3];
  logic [AW-1:0] tbl_addr [0:3];
  logic [DW-1:0] tbl_exp  [0:3];

  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  int   hold_len = 0;
  int   run_len = 0;
  int   top_cyc = 0;
  int   done_at = 1;
  bit   done_en = 1'b0;
  logic fin_d = 1'b0;
  exp_t sb [$];

  program_run_checker_if #(.DW(DW), .AW(AW), .NUM_CHECKS(N)) bus ();

  program_run_checker #(
    .DW(DW), .AW(AW), .NUM_CHECKS(N), .RST_CYCLES(RST), .TIMEOUT(TO), .CW(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bus(bus),
    .busy(busy),
    .finished(finished),
    .pass(pass),
    .timed_out(timed_out),
    .err_count(err_count),
    .first_err_idx(first_err_idx)
`ifdef CYCLE_COUNT_EN
    ,
    .run_cycles(run_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Minimal processor model: counts cycles out of reset and raises done at cycle done_at
  always_ff @(posedge clk) begin
    if (bus.dut_reset) top_cyc <= 0;
    else               top_cyc <= top_cyc + 1;
  end

  assign bus.dut_done   = done_en && (top_cyc >= done_at - 1);
  assign bus.chk_sel    = tbl_sel[bus.chk_idx];
  assign bus.chk_addr   = tbl_addr[bus.chk_idx];
  assign bus.chk_exp    = tbl_exp[bus.chk_idx];
  assign bus.probe_data = bus.probe_sel ? mem[bus.probe_addr] : regs[bus.probe_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic setEntry(input int i, input logic sel, input logic [AW-1:0] addr, input logic [DW-1:0] ev);
    tbl_sel[i]  = sel;
    tbl_addr[i] = addr;
    tbl_exp[i]  = ev;
  endtask

  function automatic exp_t predict(input int d_at, input bit d_en);
    exp_t e;
    logic [DW-1:0] actual;
    e.err = 0;
    e.first = 0;
    if (!d_en || d_at > TO) begin
      e.to = 1'b1;
      e.pass = 1'b0;
      e.idx = 0;
      e.runlen = TO;
      e.cyc = TO;
    end else begin
      for (int i = 0; i < N; i++) begin
        actual = tbl_sel[i] ? mem[tbl_addr[i]] : regs[tbl_addr[i]];
        if (actual != tbl_exp[i]) begin
          if (e.err == 0) e.first = i;
          e.err++;
        end
      end
      e.to = 1'b0;
      e.pass = (e.err == 0);
      e.idx = N - 1;
      e.runlen = d_at + 2 * N;
      e.cyc = d_at;
    end
    return e;
  endfunction

  // Watches the run, measures phase lengths and retires one scoreboard entry per result
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      fin_d = 1'b0;
    end else begin
      if (busy && bus.dut_reset)  hold_len++;
      if (busy && !bus.dut_reset) run_len++;
      if (finished && !fin_d) begin
        checkOutput("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("busy_done", busy, 0);
          checkOutput("pass", pass, e.pass);
          checkOutput("timed_out", timed_out, e.to);
          checkOutput("err_count", err_count, e.err);
          checkOutput("first_err_idx", first_err_idx, e.first);
          checkOutput("chk_idx_final", bus.chk_idx, e.idx);
          checkOutput("dut_reset_done", bus.dut_reset, 0);
          checkOutput("hold_len", hold_len, RST);
          checkOutput("run_len", run_len, e.runlen);
`ifdef CYCLE_COUNT_EN
          checkOutput("run_cycles", run_cycles, e.cyc);
`endif
        end
        pops++;
      end
      fin_d = finished;
    end
  end

  task automatic applyStimulus(input int d_at, input bit d_en, input int extra_start);
    int want;
    want = pops + 1;
    sb.push_back(predict(d_at, d_en));
    @(negedge clk);
    done_at = d_at;
    done_en = d_en;
    start = 1'b1;
    hold_len = 0;
    run_len = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_finished", finished, 0);
    checkOutput("start_err_clr", err_count, 0);
    checkOutput("start_to_clr", timed_out, 0);
    checkOutput("start_pass_clr", pass, 0);
    checkOutput("start_dut_reset", bus.dut_reset, 1);
    if (extra_start > 0) begin
      repeat (extra_start) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 200 && pops < want; i++) @(posedge clk);
    if (pops < want) checkOutput("result_wait", pops, want);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      regs[i] = DW'(i * 5 + 1);
      mem[i]  = DW'(i * 7 + 2);
    end
    regs[6] = 8'd3;
    regs[1] = 8'd2;
    mem[0]  = 8'd6;
    mem[1]  = 8'd3;
    for (int i = 0; i < 4; i++) setEntry(i, 1'b0, 8'd6, 8'd3);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dut_reset", bus.dut_reset, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_finished", finished, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_timed_out", timed_out, 0);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_first_err", first_err_idx, 0);
    checkOutput("rst_chk_idx", bus.chk_idx, 0);
`ifdef CYCLE_COUNT_EN
    checkOutput("rst_run_cycles", run_cycles, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    setEntry(0, 1'b0, 8'd6, 8'd3);
    setEntry(1, 1'b1, 8'd1, 8'd3);
    setEntry(2, 1'b0, 8'd1, 8'd2);
    applyStimulus(5, 1'b1, 0);

    setEntry(0, 1'b1, 8'd0, 8'd7);
    setEntry(1, 1'b0, 8'd1, 8'd1);
    setEntry(2, 1'b1, 8'd1, 8'd3);
    applyStimulus(4, 1'b1, 0);

    applyStimulus(1, 1'b0, 0);

    setEntry(0, 1'b0, 8'd6, 8'd3);
    setEntry(1, 1'b1, 8'd1, 8'd3);
    setEntry(2, 1'b0, 8'd1, 8'd1);
    applyStimulus(1, 1'b1, 0);

    applyStimulus(TO, 1'b1, 0);
    applyStimulus(6, 1'b1, 3);

    setEntry(0, 1'b1, 8'd0, 8'd7);
    setEntry(1, 1'b0, 8'd1, 8'd1);
    setEntry(2, 1'b1, 8'd1, 8'd3);
    @(negedge clk);
    done_at = 3;
    done_en = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 100 && bus.chk_idx != 1; i++) @(negedge clk);
    checkOutput("reach_chk1", bus.chk_idx, 1);
    @(negedge clk);
    checkOutput("pre_reset_err", err_count, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_dut_reset", bus.dut_reset, 1);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_err", err_count, 0);
    checkOutput("mid_rst_chk_idx", bus.chk_idx, 0);
    checkOutput("mid_rst_finished", finished, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3, 1'b1, 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin
        logic          s;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        s = 1'($urandom_range(0, 1));
        a = AW'($urandom_range(0, 7));
        v = s ? mem[a] : regs[a];
        if ($urandom_range(0, 1) == 1) v = v ^ 8'h10;
        setEntry(i, s, a, v);
      end
      applyStimulus(int'($urandom_range(1, 20)), 1'b1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
